// File: rtl/grant_decoder_fsm_pkg.sv
// Shared definitions for the grant decoder and future encoder-side blocks.
package grant_decoder_fsm_pkg;

    localparam int unsigned GD_N        = 4;
    localparam int unsigned GD_IDXW     = 2;
    localparam int unsigned GD_HOLD_MAX = 7;

    // 2'd3 is illegal and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } gd_state_e;

    typedef struct packed {
        logic timeout;
        logic err;
    } gd_pulse_t;

endpackage

// File: rtl/grant_decoder_fsm_if.sv
// Index/grant handshake between priority encoder, decoder and consumer.
interface grant_decoder_fsm_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDXW = 2
);
    logic            idx_valid;
    logic [IDXW-1:0] idx;
    logic            idx_ready;
    logic            done;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic            timeout;
    logic            err;

    modport master (
        output idx_valid, idx, done,
        input  idx_ready, grant, grant_valid, timeout, err
    );

    modport slave (
        input  idx_valid, idx, done,
        output idx_ready, grant, grant_valid, timeout, err
    );
endinterface

// File: rtl/grant_decoder_fsm_hold_timer.sv
// Saturating hold counter; expire flags the last permitted grant cycle.
module hold_timer #(
    parameter int unsigned HOLD_MAX = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_MAX - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/grant_decoder_fsm.sv
// Handshaked index-to-one-hot grant decoder with hold timeout and
// a mandatory dead cycle between grants.
module grant_decoder_fsm
    import grant_decoder_fsm_pkg::*;
#(
    parameter int unsigned N        = GD_N,
    parameter int unsigned IDXW     = GD_IDXW,
    parameter int unsigned HOLD_MAX = GD_HOLD_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    grant_decoder_fsm_if.slave    bus
);
    gd_state_e state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic         grant_valid_q, grant_valid_d;
    gd_pulse_t    pulse_q, pulse_d;
    logic         tmr_clr;
    logic         tmr_en;
    logic         tmr_expire;

    hold_timer #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        pulse_d       = '0;
        tmr_clr       = 1'b1;
        tmr_en        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                if (bus.idx_valid) begin
                    if (32'(bus.idx) < N) begin
                        grant_d       = N'(1) << bus.idx;
                        grant_valid_d = 1'b1;
                        state_d       = ST_GRANT;
                    end else begin
                        pulse_d.err = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                // done has priority over a coincident timer expiry
                if (bus.done || tmr_expire) begin
                    grant_d         = '0;
                    grant_valid_d   = 1'b0;
                    pulse_d.timeout = !bus.done;
                    state_d         = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            pulse_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            pulse_q       <= pulse_d;
        end
    end

    assign bus.idx_ready   = (state_q == ST_IDLE);
    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout     = pulse_q.timeout;
    assign bus.err         = pulse_q.err;

endmodule

// File: tb/tb_grant_decoder_fsm.sv
// Bench: two decoders (N=4/HOLD 7 and N=3/HOLD 3) share one stimulus stream,
// each compared every cycle against a transaction-level ownership model.
module tb_grant_decoder_fsm;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    grant_decoder_fsm_if #(.N(4), .IDXW(2)) ia ();
    grant_decoder_fsm_if #(.N(3), .IDXW(2)) ib ();

    grant_decoder_fsm #(.N(4), .IDXW(2), .HOLD_MAX(7)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.slave)
    );

    grant_decoder_fsm #(.N(3), .IDXW(2), .HOLD_MAX(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who owns the resource, for how many cycles, and whether a dead cycle is due
    int nreq [2] = '{4, 3};
    int hmax [2] = '{7, 3};
    int owner[2];
    int held [2];
    bit dead [2];
    bit e_to [2];
    bit e_err[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, want);
        end
    endtask

    function automatic logic [31:0] want_grant(input int k);
        return (owner[k] >= 0) ? (32'd1 << owner[k]) : 32'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1;
            held[k]  = 0;
            dead[k]  = 1'b0;
            e_to[k]  = 1'b0;
            e_err[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit v, input int ix, input bit d);
        for (int k = 0; k < 2; k++) begin
            e_to[k]  = 1'b0;
            e_err[k] = 1'b0;
            if (dead[k]) begin
                dead[k] = 1'b0;
            end else if (owner[k] >= 0) begin
                if (d) begin
                    owner[k] = -1;
                    dead[k]  = 1'b1;
                end else if (held[k] == hmax[k]) begin
                    owner[k] = -1;
                    dead[k]  = 1'b1;
                    e_to[k]  = 1'b1;
                end else begin
                    held[k]++;
                end
            end else if (v) begin
                if (ix < nreq[k]) begin
                    owner[k] = ix;
                    held[k]  = 1;
                end else begin
                    e_err[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        check("a_grant",   32'(ia.grant),       want_grant(0));
        check("a_gvalid",  32'(ia.grant_valid), 32'(owner[0] >= 0));
        check("a_ready",   32'(ia.idx_ready),   32'(owner[0] < 0 && !dead[0]));
        check("a_timeout", 32'(ia.timeout),     32'(e_to[0]));
        check("a_err",     32'(ia.err),         32'(e_err[0]));
        check("b_grant",   32'(ib.grant),       want_grant(1));
        check("b_gvalid",  32'(ib.grant_valid), 32'(owner[1] >= 0));
        check("b_ready",   32'(ib.idx_ready),   32'(owner[1] < 0 && !dead[1]));
        check("b_timeout", 32'(ib.timeout),     32'(e_to[1]));
        check("b_err",     32'(ib.err),         32'(e_err[1]));
    endtask

    task automatic drive(input bit v, input logic [1:0] ix, input bit d);
        ia.idx_valid = v;
        ib.idx_valid = v;
        ia.idx       = ix;
        ib.idx       = ix;
        ia.done      = d;
        ib.done      = d;
    endtask

    // One cycle: check settled outputs, apply inputs, advance the model at the edge
    task automatic step(input bit v, input logic [1:0] ix, input bit d);
        @(negedge clk);
        check_all();
        drive(v, ix, d);
        @(posedge clk);
        model_step(v, int'(ix), d);
    endtask

    // Asserted between edges so the async clear is visible before any clock
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0);
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(posedge clk);
        model_step(1'b0, 0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 2'd0, 1'b0);
        model_reset();
        do_reset();

        // idx 2, done on the third grant cycle
        step(1'b1, 2'd2, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0);

        // idx 1, no done: hold timeout
        step(1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 2'd0, 1'b0);

        // idx 3, done on the 7th grant cycle (err on the N=3 decoder)
        step(1'b1, 2'd3, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0);

        // back-to-back sweep with idx_valid held high
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'(i), 1'b0);
            step(1'b1, 2'(i), 1'b1);
            step(1'b1, 2'(i), 1'b0);
        end
        step(1'b0, 2'd0, 1'b0);

        // reset while granting
        step(1'b1, 2'd3, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        do_reset();
        step(1'b0, 2'd0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(9) < 6, 2'($urandom_range(3)), $urandom_range(99) < 15);
            end
        end
        @(negedge clk);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
